// File: rtl/gps_ack_corr_bank_pkg.sv
// Shared types for the acquisition correlator bank: search tag layout, FSM states, +-1 mixer.
// Pure declarations; no clocked logic here.
package gps_ack_pkg;

    typedef struct packed {
        logic [9:0]  code_phase;
        logic [4:0]  code_nco_frac;
        logic [15:0] doppler_omega;
    } tag_t;

    typedef enum logic [1:0] {IDLE, COH, DUMP, PEAK} state_t;

    typedef struct packed {
        logic signed [2:0] i;
        logic signed [2:0] q;
    } iq_t;

    // Sign bits map 1 -> +1, 0 -> -1; products land in {-2,0,+2}.
    function automatic iq_t mix_pm1(input logic si, input logic sq, input logic ci, input logic cq);
        logic signed [2:0] psi, psq, pci, pcq;
        iq_t r;
        psi = si ? 3'sd1 : -3'sd1;
        psq = sq ? 3'sd1 : -3'sd1;
        pci = ci ? 3'sd1 : -3'sd1;
        pcq = cq ? 3'sd1 : -3'sd1;
        r.i = psi * pci + psq * pcq;
        r.q = psq * pci - psi * pcq;
        return r;
    endfunction

endpackage

// File: rtl/gps_ack_corr_bank_if.sv
// Sample/control/result bundle between NCO front end, search control and the correlator bank.
// master drives samples and commands; slave is the correlator.
interface gps_ack_corr_bank_if #(
    parameter int NUM_CH = 8,
    parameter int NC_W   = 20,
    parameter int TAG_W  = 31
);
    logic                    ack_start;
    logic [TAG_W-1:0]        tag_in;
    logic                    clear_peaks;
    logic                    adc_clk;
    logic                    i_sample;
    logic                    q_sample;
    logic                    carrier_i;
    logic                    carrier_q;
    logic [NUM_CH-1:0]       code_chip;
    logic                    busy;
    logic                    corr_complete;
    logic [NUM_CH*NC_W-1:0]  mag;
    logic [NUM_CH*NC_W-1:0]  peak_mag;
    logic [NUM_CH*TAG_W-1:0] peak_tag;
    logic [NUM_CH-1:0]       peak_valid;
    logic                    overrun;

    modport master (
        output ack_start, tag_in, clear_peaks, adc_clk, i_sample, q_sample,
               carrier_i, carrier_q, code_chip,
        input  busy, corr_complete, mag, peak_mag, peak_tag, peak_valid, overrun
    );

    modport slave (
        input  ack_start, tag_in, clear_peaks, adc_clk, i_sample, q_sample,
               carrier_i, carrier_q, code_chip,
        output busy, corr_complete, mag, peak_mag, peak_tag, peak_valid, overrun
    );
endinterface

// File: rtl/gps_ack_corr_bank_ch.sv
// One correlator channel: saturating coherent I/Q accumulators, |I|+|Q| non-coherent sum, peak/tag hold.
// Accumulates on acc_en the same cycle; no backpressure, strobes are consumed or ignored.
module gps_ack_ch
    import gps_ack_pkg::*;
#(
    parameter int INT_W = 15,
    parameter int NC_W  = 20,
    parameter int TAG_W = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             acc_en,
    input  logic             dump,
    input  logic             peak,
    input  logic             clear_peaks,
    input  iq_t              iq,
    input  logic             chip,
    input  logic [TAG_W-1:0] tag,
    output logic [NC_W-1:0]  mag,
    output logic [NC_W-1:0]  peak_mag,
    output logic [TAG_W-1:0] peak_tag,
    output logic             peak_valid
);
    localparam logic signed [INT_W:0] MAXS = (INT_W+1)'(2**(INT_W-1) - 1);

    // Symmetric clamp keeps |acc| representable in INT_W-1 magnitude bits.
    function automatic logic signed [INT_W-1:0] sat_add(input logic signed [INT_W-1:0] a,
                                                         input logic signed [2:0] b);
        logic signed [INT_W:0] s;
        s = {a[INT_W-1], a} + {{(INT_W-2){b[2]}}, b};
        if (s > MAXS)  return MAXS[INT_W-1:0];
        if (s < -MAXS) return (-MAXS);
        return s[INT_W-1:0];
    endfunction

    logic signed [INT_W-1:0] acc_i, acc_q;
    logic signed [2:0]       prod_i, prod_q;
    logic [INT_W-1:0]        abs_i, abs_q, mag_sum;
    logic [NC_W:0]           nc_sum;
    logic [NC_W-1:0]         nc_acc, nc_next;

    always_comb begin
        prod_i  = chip ? iq.i : -iq.i;
        prod_q  = chip ? iq.q : -iq.q;
        abs_i   = acc_i[INT_W-1] ? $unsigned(-acc_i) : $unsigned(acc_i);
        abs_q   = acc_q[INT_W-1] ? $unsigned(-acc_q) : $unsigned(acc_q);
        mag_sum = abs_i + abs_q;
        nc_sum  = {1'b0, nc_acc} + (NC_W+1)'(mag_sum);
        nc_next = nc_sum[NC_W] ? '1 : nc_sum[NC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_i      <= '0;
            acc_q      <= '0;
            nc_acc     <= '0;
            mag        <= '0;
            peak_mag   <= '0;
            peak_tag   <= '0;
            peak_valid <= 1'b0;
        end else begin
            if (start || dump) begin
                acc_i <= '0;
                acc_q <= '0;
            end else if (acc_en) begin
                acc_i <= sat_add(acc_i, prod_i);
                acc_q <= sat_add(acc_q, prod_q);
            end
            if (start)     nc_acc <= '0;
            else if (dump) nc_acc <= nc_next;
            if (peak)      mag <= nc_acc;
            // A clear on the PEAK cycle wins; that point's peak update is discarded.
            if (clear_peaks) begin
                peak_mag   <= '0;
                peak_tag   <= '0;
                peak_valid <= 1'b0;
            end else if (peak && (nc_acc > peak_mag || !peak_valid)) begin
                peak_mag   <= nc_acc;
                peak_tag   <= tag;
                peak_valid <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/gps_ack_corr_bank.sv
// NUM_CH-channel acquisition correlator: FSM, sample/dump counters, tag capture, overrun; corr_complete 2 cycles
// after the last sample (NONCOH_NUM=1). No backpressure: strobes in DUMP/PEAK are dropped and flag overrun.
module gps_ack_corr_bank
    import gps_ack_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int SAMPLE_NUM = 8191,
    parameter int NONCOH_NUM = 1,
    parameter int INT_W      = 15,
    parameter int NC_W       = 20,
    parameter int TAG_W      = 31
) (
    input  logic               clk,
    input  logic               rst,
    gps_ack_corr_bank_if.slave bus
);
    localparam int SC_W = (SAMPLE_NUM > 0) ? $clog2(SAMPLE_NUM + 1) : 1;
    localparam int DC_W = (NONCOH_NUM > 1) ? $clog2(NONCOH_NUM) : 1;

    state_t            state, state_nxt;
    logic [SC_W-1:0]   sample_cnt;
    logic [DC_W-1:0]   dump_cnt;
    logic [TAG_W-1:0]  tag_q;
    logic              corr_complete_q, overrun_q;
    logic              start, samp_en, last_sample, last_dump, is_dump, is_peak;
    iq_t               iq;

    assign start       = (state == IDLE) && bus.ack_start;
    assign samp_en     = (state == COH) && bus.adc_clk;
    assign last_sample = (sample_cnt == SC_W'(SAMPLE_NUM));
    assign last_dump   = (dump_cnt == DC_W'(NONCOH_NUM - 1));
    assign is_dump     = (state == DUMP);
    assign is_peak     = (state == PEAK);
    assign iq          = mix_pm1(bus.i_sample, bus.q_sample, bus.carrier_i, bus.carrier_q);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COH;
            COH:     if (samp_en && last_sample) state_nxt = DUMP;
            DUMP:    state_nxt = last_dump ? PEAK : COH;
            PEAK:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt      <= '0;
            dump_cnt        <= '0;
            tag_q           <= '0;
            corr_complete_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            if (start) begin
                sample_cnt <= '0;
                dump_cnt   <= '0;
                tag_q      <= bus.tag_in;
            end else begin
                if (samp_en)              sample_cnt <= last_sample ? '0 : sample_cnt + SC_W'(1);
                if (is_dump && !last_dump) dump_cnt  <= dump_cnt + DC_W'(1);
            end
            corr_complete_q <= is_peak;
            if ((is_dump || is_peak) && bus.adc_clk) overrun_q <= 1'b1;
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.corr_complete = corr_complete_q;
    assign bus.overrun       = overrun_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        gps_ack_ch #(.INT_W(INT_W), .NC_W(NC_W), .TAG_W(TAG_W)) u_ch (
            .clk         (clk),
            .rst         (rst),
            .start       (start),
            .acc_en      (samp_en),
            .dump        (is_dump),
            .peak        (is_peak),
            .clear_peaks (bus.clear_peaks),
            .iq          (iq),
            .chip        (bus.code_chip[k]),
            .tag         (tag_q),
            .mag         (bus.mag[k*NC_W +: NC_W]),
            .peak_mag    (bus.peak_mag[k*NC_W +: NC_W]),
            .peak_tag    (bus.peak_tag[k*TAG_W +: TAG_W]),
            .peak_valid  (bus.peak_valid[k])
        );
    end
endmodule

// File: tb/tb_gps_ack_corr_bank.sv
// Directed bench for gps_ack_corr_bank: three parameterisations share stimulus, each has its own ack_start.
module tb_gps_ack_corr_bank;
    import gps_ack_pkg::*;

    localparam tag_t TAG_A = '{code_phase: 10'd17,  code_nco_frac: 5'd3,  doppler_omega: 16'h1234};
    localparam tag_t TAG_B = '{code_phase: 10'd300, code_nco_frac: 5'd9,  doppler_omega: 16'hBEEF};
    localparam tag_t TAG_C = '{code_phase: 10'd511, code_nco_frac: 5'd30, doppler_omega: 16'h0F0F};
    localparam tag_t TAG_D = '{code_phase: 10'd5,   code_nco_frac: 5'd1,  doppler_omega: 16'hA5A5};
    localparam tag_t TAG_F = '{code_phase: 10'd900, code_nco_frac: 5'd17, doppler_omega: 16'h7777};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ack_a = 1'b0, ack_b = 1'b0, ack_c = 1'b0;
    logic [30:0] tag = '0;
    logic clr = 1'b0, adc = 1'b0, i_s = 1'b1, q_s = 1'b1, c_i = 1'b1, c_q = 1'b0;
    logic chip0 = 1'b1, chip1 = 1'b1;
    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    gps_ack_corr_bank_if #(.NUM_CH(2), .NC_W(20), .TAG_W(31)) if_a ();
    gps_ack_corr_bank_if #(.NUM_CH(2), .NC_W(20), .TAG_W(31)) if_b ();
    gps_ack_corr_bank_if #(.NUM_CH(2), .NC_W(20), .TAG_W(31)) if_c ();

    assign if_a.ack_start = ack_a;
    assign if_b.ack_start = ack_b;
    assign if_c.ack_start = ack_c;
    assign {if_a.tag_in, if_b.tag_in, if_c.tag_in} = {3{tag}};
    assign {if_a.clear_peaks, if_b.clear_peaks, if_c.clear_peaks} = {3{clr}};
    assign {if_a.adc_clk, if_b.adc_clk, if_c.adc_clk} = {3{adc}};
    assign {if_a.i_sample, if_b.i_sample, if_c.i_sample} = {3{i_s}};
    assign {if_a.q_sample, if_b.q_sample, if_c.q_sample} = {3{q_s}};
    assign {if_a.carrier_i, if_b.carrier_i, if_c.carrier_i} = {3{c_i}};
    assign {if_a.carrier_q, if_b.carrier_q, if_c.carrier_q} = {3{c_q}};
    assign {if_a.code_chip, if_b.code_chip, if_c.code_chip} = {3{chip1, chip0}};

    gps_ack_corr_bank #(.NUM_CH(2), .SAMPLE_NUM(15), .NONCOH_NUM(1), .INT_W(15), .NC_W(20), .TAG_W(31))
        u_a (.clk(clk), .rst(rst), .bus(if_a));
    gps_ack_corr_bank #(.NUM_CH(2), .SAMPLE_NUM(15), .NONCOH_NUM(4), .INT_W(15), .NC_W(20), .TAG_W(31))
        u_b (.clk(clk), .rst(rst), .bus(if_b));
    gps_ack_corr_bank #(.NUM_CH(2), .SAMPLE_NUM(63), .NONCOH_NUM(1), .INT_W(6), .NC_W(20), .TAG_W(31))
        u_c (.clk(clk), .rst(rst), .bus(if_c));

    function automatic logic get_busy(input int w);
        case (w)
            0:       return if_a.busy;
            1:       return if_b.busy;
            default: return if_c.busy;
        endcase
    endfunction

    function automatic logic get_cc(input int w);
        case (w)
            0:       return if_a.corr_complete;
            1:       return if_b.corr_complete;
            default: return if_c.corr_complete;
        endcase
    endfunction

    task automatic set_ack(input int w, input logic v);
        ack_a = (w == 0) ? v : 1'b0;
        ack_b = (w == 1) ? v : 1'b0;
        ack_c = (w == 2) ? v : 1'b0;
    endtask

    function automatic logic chip_of(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 2 == 0);
            2:       return 1'($urandom_range(0, 1));
            default: return 1'b0;
        endcase
    endfunction

    // Runs one search point; a gap cycle follows every per_dump samples so strobes avoid intermediate DUMPs.
    // Reports corr_complete count, its cycle index after the last strobe, busy-low cycles and ch0 '1' chips.
    task automatic run_point(input int w, input logic [30:0] t, input int nsamp, input int per_dump,
                             input int m0, input int m1, input bit gap_adc, input bit mid_evt,
                             input bit clr_peak, output int cc_cnt, output int cc_idx,
                             output int busy_lo, output int ones0);
        cc_cnt = 0; cc_idx = -1; busy_lo = 0; ones0 = 0;
        @(negedge clk);
        tag = t; set_ack(w, 1'b1);
        for (int k = 0; k < nsamp; k++) begin
            if (k > 0 && k % per_dump == 0) begin
                @(negedge clk);
                set_ack(w, 1'b0); clr = 1'b0; tag = t;
                if (!get_busy(w)) busy_lo++;
                adc = gap_adc; chip0 = 1'b1; chip1 = 1'b1;
            end
            @(negedge clk);
            set_ack(w, 1'b0); clr = 1'b0; tag = t;
            if (!get_busy(w)) busy_lo++;
            adc = 1'b1; chip0 = chip_of(m0, k); chip1 = chip_of(m1, k);
            if (chip0) ones0++;
            if (mid_evt && k == 5) begin
                set_ack(w, 1'b1); tag = t ^ 31'h5A5A_5A5A; clr = 1'b1;
            end
        end
        for (int idx = 0; idx < 10; idx++) begin
            @(negedge clk);
            adc = 1'b0; set_ack(w, 1'b0); tag = t;
            clr = (clr_peak && idx == 1);
            if (get_cc(w)) begin
                cc_cnt++;
                if (cc_idx < 0) cc_idx = idx;
            end else if (cc_cnt == 0 && !get_busy(w)) busy_lo++;
        end
        clr = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++; if (if_a.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", if_a.busy); end
        tests_run++; if (if_a.corr_complete !== 1'b0) begin tests_failed++; $display("FAIL reset_cc: got %0b want 0", if_a.corr_complete); end
        tests_run++; if (if_a.mag !== 40'd0) begin tests_failed++; $display("FAIL reset_mag: got %h want 0", if_a.mag); end
        tests_run++; if (if_a.peak_valid !== 2'b00) begin tests_failed++; $display("FAIL reset_pv: got %b want 00", if_a.peak_valid); end
        tests_run++; if (if_a.overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %0b want 0", if_a.overrun); end
        tests_run++; if (if_b.peak_tag !== 62'd0) begin tests_failed++; $display("FAIL reset_ptag: got %h want 0", if_b.peak_tag); end
    endtask

    task automatic test_basic();
        int cc, ci, bl, o;
        run_point(0, TAG_A, 16, 16, 0, 1, 1'b0, 1'b0, 1'b0, cc, ci, bl, o);
        tests_run++; if (cc !== 1) begin tests_failed++; $display("FAIL basic_cc_count: got %0d want 1", cc); end
        tests_run++; if (ci !== 2) begin tests_failed++; $display("FAIL basic_latency: got %0d want 2", ci); end
        tests_run++; if (bl !== 0) begin tests_failed++; $display("FAIL basic_busy: busy low %0d cycles, want 0", bl); end
        tests_run++; if (if_a.mag[19:0] !== 20'd32) begin tests_failed++; $display("FAIL basic_mag0: got %0d want 32", if_a.mag[19:0]); end
        tests_run++; if (if_a.mag[39:20] !== 20'd0) begin tests_failed++; $display("FAIL basic_mag1: got %0d want 0", if_a.mag[39:20]); end
        tests_run++; if (if_a.peak_valid !== 2'b11) begin tests_failed++; $display("FAIL basic_pv: got %b want 11", if_a.peak_valid); end
        tests_run++; if (if_a.peak_tag[30:0] !== TAG_A) begin tests_failed++; $display("FAIL basic_ptag0: got %h want %h", if_a.peak_tag[30:0], TAG_A); end
        tests_run++; if (if_a.peak_mag[19:0] !== 20'd32) begin tests_failed++; $display("FAIL basic_pmag0: got %0d want 32", if_a.peak_mag[19:0]); end
        tests_run++; if (if_a.overrun !== 1'b0) begin tests_failed++; $display("FAIL basic_overrun: got %0b want 0", if_a.overrun); end
    endtask

    task automatic test_two_points();
        int cc, ci, bl, o, e;
        run_point(0, TAG_B, 16, 16, 2, 0, 1'b0, 1'b0, 1'b0, cc, ci, bl, o);
        e = 4 * o - 32;
        if (e < 0) e = -e;
        tests_run++; if (if_a.mag[19:0] !== 20'(e)) begin tests_failed++; $display("FAIL two_mag0: got %0d want %0d", if_a.mag[19:0], e); end
        tests_run++; if (if_a.peak_tag[30:0] !== TAG_A) begin tests_failed++; $display("FAIL two_ptag0: got %h want %h", if_a.peak_tag[30:0], TAG_A); end
        tests_run++; if (if_a.peak_mag[19:0] !== 20'd32) begin tests_failed++; $display("FAIL two_pmag0: got %0d want 32", if_a.peak_mag[19:0]); end
        tests_run++; if (if_a.peak_tag[61:31] !== TAG_B) begin tests_failed++; $display("FAIL two_ptag1: got %h want %h", if_a.peak_tag[61:31], TAG_B); end
        run_point(0, TAG_C, 16, 16, 0, 1, 1'b0, 1'b0, 1'b0, cc, ci, bl, o);
        tests_run++; if (if_a.mag[19:0] !== 20'd32) begin tests_failed++; $display("FAIL tie_mag0: got %0d want 32", if_a.mag[19:0]); end
        tests_run++; if (if_a.peak_tag[30:0] !== TAG_A) begin tests_failed++; $display("FAIL tie_ptag0: got %h want %h", if_a.peak_tag[30:0], TAG_A); end
        tests_run++; if (if_a.peak_tag[61:31] !== TAG_B) begin tests_failed++; $display("FAIL tie_ptag1: got %h want %h", if_a.peak_tag[61:31], TAG_B); end
        tests_run++; if (if_a.peak_mag[39:20] !== 20'd32) begin tests_failed++; $display("FAIL tie_pmag1: got %0d want 32", if_a.peak_mag[39:20]); end
    endtask

    task automatic test_noncoh();
        int cc, ci, bl, o;
        run_point(1, TAG_B, 64, 16, 0, 1, 1'b0, 1'b0, 1'b0, cc, ci, bl, o);
        tests_run++; if (cc !== 1) begin tests_failed++; $display("FAIL nc_cc_count: got %0d want 1", cc); end
        tests_run++; if (ci !== 2) begin tests_failed++; $display("FAIL nc_latency: got %0d want 2", ci); end
        tests_run++; if (bl !== 0) begin tests_failed++; $display("FAIL nc_busy: busy low %0d cycles, want 0", bl); end
        tests_run++; if (if_b.mag[19:0] !== 20'd128) begin tests_failed++; $display("FAIL nc_mag0: got %0d want 128", if_b.mag[19:0]); end
        tests_run++; if (if_b.mag[39:20] !== 20'd0) begin tests_failed++; $display("FAIL nc_mag1: got %0d want 0", if_b.mag[39:20]); end
        tests_run++; if (if_b.overrun !== 1'b0) begin tests_failed++; $display("FAIL nc_overrun: got %0b want 0", if_b.overrun); end
    endtask

    task automatic test_saturation();
        int cc, ci, bl, o;
        run_point(2, TAG_C, 64, 64, 0, 3, 1'b0, 1'b0, 1'b0, cc, ci, bl, o);
        tests_run++; if (cc !== 1) begin tests_failed++; $display("FAIL sat_cc_count: got %0d want 1", cc); end
        tests_run++; if (if_c.mag[19:0] !== 20'd31) begin tests_failed++; $display("FAIL sat_mag0_pos: got %0d want 31", if_c.mag[19:0]); end
        tests_run++; if (if_c.mag[39:20] !== 20'd31) begin tests_failed++; $display("FAIL sat_mag1_neg: got %0d want 31", if_c.mag[39:20]); end
    endtask

    task automatic test_overrun_busy_ack();
        int cc, ci, bl, o;
        run_point(1, TAG_D, 64, 16, 0, 1, 1'b1, 1'b1, 1'b0, cc, ci, bl, o);
        tests_run++; if (if_b.overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag: got %0b want 1", if_b.overrun); end
        tests_run++; if (cc !== 1) begin tests_failed++; $display("FAIL ovr_cc_count: got %0d want 1", cc); end
        tests_run++; if (ci !== 2) begin tests_failed++; $display("FAIL ovr_latency: got %0d want 2", ci); end
        tests_run++; if (if_b.mag[19:0] !== 20'd128) begin tests_failed++; $display("FAIL ovr_mag0: got %0d want 128", if_b.mag[19:0]); end
        tests_run++; if (if_b.peak_tag[30:0] !== TAG_D) begin tests_failed++; $display("FAIL busy_ack_tag: got %h want %h", if_b.peak_tag[30:0], TAG_D); end
        tests_run++; if (if_b.peak_mag[19:0] !== 20'd128) begin tests_failed++; $display("FAIL coh_clear_pmag0: got %0d want 128", if_b.peak_mag[19:0]); end
        tests_run++; if (if_b.peak_valid !== 2'b11) begin tests_failed++; $display("FAIL coh_clear_pv: got %b want 11", if_b.peak_valid); end
    endtask

    task automatic test_clear_on_peak();
        int cc, ci, bl, o;
        run_point(0, TAG_F, 16, 16, 0, 0, 1'b0, 1'b0, 1'b1, cc, ci, bl, o);
        tests_run++; if (cc !== 1) begin tests_failed++; $display("FAIL clr_cc_count: got %0d want 1", cc); end
        tests_run++; if (if_a.peak_valid !== 2'b00) begin tests_failed++; $display("FAIL clr_pv: got %b want 00", if_a.peak_valid); end
        tests_run++; if (if_a.peak_mag !== 40'd0) begin tests_failed++; $display("FAIL clr_pmag: got %h want 0", if_a.peak_mag); end
        tests_run++; if (if_a.peak_tag !== 62'd0) begin tests_failed++; $display("FAIL clr_ptag: got %h want 0", if_a.peak_tag); end
        tests_run++; if (if_a.mag !== {20'd32, 20'd32}) begin tests_failed++; $display("FAIL clr_mag: got %h want %h", if_a.mag, {20'd32, 20'd32}); end
    endtask

    task automatic test_rst_mid();
        int cc = 0;
        int bh = 0;
        @(negedge clk);
        tag = TAG_A; set_ack(0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            set_ack(0, 1'b0); adc = 1'b1; chip0 = 1'b1; chip1 = 1'b1;
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        tests_run++; if (if_a.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %0b want 0", if_a.busy); end
        tests_run++; if (if_b.overrun !== 1'b0) begin tests_failed++; $display("FAIL rst_overrun_b: got %0b want 0", if_b.overrun); end
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (if_a.corr_complete) cc++;
            if (if_a.busy) bh++;
        end
        adc = 1'b0;
        tests_run++; if (cc !== 0) begin tests_failed++; $display("FAIL rst_no_cc: got %0d pulses want 0", cc); end
        tests_run++; if (bh !== 0) begin tests_failed++; $display("FAIL rst_idle: busy high %0d cycles want 0", bh); end
        tests_run++; if (if_a.overrun !== 1'b0) begin tests_failed++; $display("FAIL idle_adc_overrun: got %0b want 0", if_a.overrun); end
        tests_run++; if (if_a.mag !== 40'd0) begin tests_failed++; $display("FAIL rst_mag: got %h want 0", if_a.mag); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic();
        test_two_points();
        test_noncoh();
        test_saturation();
        test_overrun_busy_ack();
        test_clear_on_peak();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
